// File: rtl/seg_snake_pkg.sv
// Shared constants and helpers for the 7-segment snake animator.
package seg_snake_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Wide enough for the largest legal display (8 digits).
   localparam int DIGIT_IDX_W = 3;

   // Number of perimeter positions around an n-digit display.
   function automatic int snake_path_len(input int num_digits);
      return 2 * num_digits + 4;
   endfunction

endpackage

// File: rtl/snake_pos_decode.sv
// Maps a perimeter position to the digit and segment it lights.
// Positions run left->right along the top, down the right edge, right->left along the bottom, up the left edge.
module snake_pos_decode
   import seg_snake_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int POS_W      = 4
) (
   input  logic [POS_W-1:0]       i_pos,
   output logic [DIGIT_IDX_W-1:0] o_digit,
   output logic [2:0]             o_seg
);

   int w_p;

   assign w_p = int'(i_pos);

   always_comb begin
      o_digit = '0;
      o_seg   = 3'(SEG_F);
      if (w_p < NUM_DIGITS) begin
         o_digit = DIGIT_IDX_W'(w_p);
         o_seg   = 3'(SEG_A);
      end else if (w_p == NUM_DIGITS) begin
         o_digit = DIGIT_IDX_W'(NUM_DIGITS - 1);
         o_seg   = 3'(SEG_B);
      end else if (w_p == NUM_DIGITS + 1) begin
         o_digit = DIGIT_IDX_W'(NUM_DIGITS - 1);
         o_seg   = 3'(SEG_C);
      end else if (w_p <= 2 * NUM_DIGITS + 1) begin
         o_digit = DIGIT_IDX_W'(2 * NUM_DIGITS + 1 - w_p);
         o_seg   = 3'(SEG_D);
      end else if (w_p == 2 * NUM_DIGITS + 2) begin
         o_digit = '0;
         o_seg   = 3'(SEG_E);
      end
   end

endmodule

// File: rtl/seg_snake_engine.sv
// Snake animation around the outer perimeter of a row of active-low 7-segment digits.
// Build option: define SNAKE_DP_HEAD_EN to light the decimal point of the digit holding the head.
module seg_snake_engine
   import seg_snake_pkg::*;
#(
   parameter  int NUM_DIGITS = 4,
   parameter  int SNAKE_LEN  = 3,
   parameter  int TICK_DIV   = 5_000_000,
   localparam int L          = snake_path_len(NUM_DIGITS),
   localparam int POS_W      = $clog2(L)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    run,
   input  logic                    dir,
   input  logic                    step,
   output logic [7*NUM_DIGITS-1:0] seg,
   output logic [NUM_DIGITS-1:0]   dp,
   output logic [POS_W-1:0]        head_pos,
   output logic                    wrap
);

   localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_TC   = CNT_W'(TICK_DIV - 1);
   localparam logic [POS_W-1:0]  POS_LAST = POS_W'(L - 1);
   localparam logic [POS_W:0]    LEN_W    = (POS_W+1)'(L);

   logic [POS_W-1:0]        r_head;
   logic [CNT_W-1:0]        r_presc;
   logic                    r_step;
   logic                    r_wrap;
   logic [7*NUM_DIGITS-1:0] r_seg;

   logic                    w_tick;
   logic                    w_step_rise;
   logic                    w_adv;
   logic                    w_lap;
   logic [POS_W-1:0]        w_head_nxt;
   logic [POS_W-1:0]        w_body    [SNAKE_LEN];
   logic [DIGIT_IDX_W-1:0]  w_dig     [SNAKE_LEN];
   logic [2:0]              w_seg_idx [SNAKE_LEN];
   logic [7*NUM_DIGITS-1:0] w_lit;

   assign w_tick      = run && (r_presc == CNT_TC);
   assign w_step_rise = !run && step && !r_step;
   assign w_adv       = w_tick || w_step_rise;

   always_comb begin
      w_head_nxt = r_head;
      w_lap      = 1'b0;
      if (dir) begin
         if (r_head == POS_LAST) begin
            w_head_nxt = '0;
            w_lap      = 1'b1;
         end else begin
            w_head_nxt = r_head + POS_W'(1);
         end
      end else begin
         if (r_head == '0) begin
            w_head_nxt = POS_LAST;
            w_lap      = 1'b1;
         end else begin
            w_head_nxt = r_head - POS_W'(1);
         end
      end
   end

   // Body element i sits i places behind the head, against the direction of travel.
   for (genvar gi = 0; gi < SNAKE_LEN; gi++) begin : g_body
      localparam logic [POS_W:0] OFF_CW  = (POS_W+1)'((L - gi) % L);
      localparam logic [POS_W:0] OFF_CCW = (POS_W+1)'(gi);

      logic [POS_W:0] w_sum;

      assign w_sum        = {1'b0, r_head} + (dir ? OFF_CW : OFF_CCW);
      assign w_body[gi]   = (w_sum >= LEN_W) ? POS_W'(w_sum - LEN_W) : POS_W'(w_sum);

      snake_pos_decode #(
         .NUM_DIGITS (NUM_DIGITS),
         .POS_W      (POS_W)
      ) u_dec (
         .i_pos   (w_body[gi]),
         .o_digit (w_dig[gi]),
         .o_seg   (w_seg_idx[gi])
      );
   end

   always_comb begin
      w_lit = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         for (int s = SEG_A; s <= SEG_F; s++) begin
            for (int i = 0; i < SNAKE_LEN; i++) begin
               if ((w_dig[i] == DIGIT_IDX_W'(k)) && (w_seg_idx[i] == 3'(s))) begin
                  w_lit[7*k + s] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_presc <= '0;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
         r_seg   <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         r_step <= step;
         if (!run || w_tick) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + CNT_W'(1);
         end
         r_wrap <= w_adv && w_lap;
         if (w_adv) begin
            r_head <= w_head_nxt;
         end
         r_seg <= ~w_lit;
      end
   end

`ifdef SNAKE_DP_HEAD_EN
   logic [NUM_DIGITS-1:0] r_dp;
   logic [NUM_DIGITS-1:0] w_dp_nxt;

   // Element 0 of the body is the head.
   always_comb begin
      w_dp_nxt = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (w_dig[0] == DIGIT_IDX_W'(k)) begin
            w_dp_nxt[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dp <= '1;
      end else begin
         r_dp <= w_dp_nxt;
      end
   end

   assign dp = r_dp;
`else
   assign dp = '1;
`endif

   assign seg      = r_seg;
   assign head_pos = r_head;
   assign wrap     = r_wrap;

endmodule

// File: tb/tb_seg_snake_engine.sv
// Self-checking bench for seg_snake_engine: vector table, directed corner sequences, random run against a model.
module tb_seg_snake_engine;

   localparam int N  = 4;
   localparam int SL = 3;
   localparam int TD = 4;
   localparam int L  = 2 * N + 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        dir = 1'b1;
   logic        step = 1'b0;
   logic [27:0] seg;
   logic [3:0]  dp;
   logic [3:0]  head_pos;
   logic        wrap;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seg_snake_engine #(
      .NUM_DIGITS (N),
      .SNAKE_LEN  (SL),
      .TICK_DIV   (TD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .dir      (dir),
      .step     (step),
      .seg      (seg),
      .dp       (dp),
      .head_pos (head_pos),
      .wrap     (wrap)
   );

   function automatic int digit_of(input int p);
      if (p < N) return p;
      if (p == N || p == N + 1) return N - 1;
      if (p <= 2 * N + 1) return 2 * N + 1 - p;
      return 0;
   endfunction

   function automatic int seg_of(input int p);
      if (p < N) return 0;
      if (p == N) return 1;
      if (p == N + 1) return 2;
      if (p <= 2 * N + 1) return 3;
      if (p == 2 * N + 2) return 4;
      return 5;
   endfunction

   function automatic logic [27:0] pattern(input int h, input bit d);
      logic [27:0] r;
      int p;
      r = '1;
      for (int i = 0; i < SL; i++) begin
         p = d ? (h - i + L) % L : (h + i) % L;
         r[7 * digit_of(p) + seg_of(p)] = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [3:0] dp_pat(input int h);
      logic [3:0] r;
      r = '1;
`ifdef SNAKE_DP_HEAD_EN
      r[digit_of(h)] = 1'b0;
`endif
      return r;
   endfunction

   // Reference model: head as an integer modulo L, updated on each clock edge.
   int          m_head  = 0;
   int          m_presc = 0;
   bit          m_step  = 1'b0;
   bit          m_wrap  = 1'b0;
   logic [27:0] m_seg   = '1;
   logic [3:0]  m_dp    = '1;

   always @(posedge clk) begin
      bit adv;
      int nh;
      if (!rst_n) begin
         m_head  = 0;
         m_presc = 0;
         m_step  = 1'b0;
         m_wrap  = 1'b0;
         m_seg   = '1;
         m_dp    = '1;
      end else begin
         adv     = run ? (m_presc == TD - 1) : (step && !m_step);
         m_seg   = pattern(m_head, dir);
         m_dp    = dp_pat(m_head);
         m_presc = (run && m_presc != TD - 1) ? m_presc + 1 : 0;
         m_step  = step;
         m_wrap  = 1'b0;
         if (adv) begin
            nh     = (m_head + (dir ? 1 : L - 1)) % L;
            m_wrap = dir ? (nh == 0) : (nh == L - 1);
            m_head = nh;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step_pulse();
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      bit          dir;
      int          steps;
      int          head;
      logic [27:0] seg;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int cyc;
      int wraps;
      int wcyc;
      int cnt;
      bit found;

      vecs[0] = '{1'b1, 0,  0,  {7'h7F, 7'h7F, 7'h7F, 7'b1001110}};
      vecs[1] = '{1'b1, 4,  4,  {7'b1111100, 7'b1111110, 7'h7F, 7'h7F}};
      vecs[2] = '{1'b0, 1,  11, {7'h7F, 7'h7F, 7'b1111110, 7'b1011110}};
      vecs[3] = '{1'b1, 7,  7,  {7'b1110011, 7'b1110111, 7'h7F, 7'h7F}};
      vecs[4] = '{1'b1, 10, 10, {7'h7F, 7'h7F, 7'b1110111, 7'b1100111}};
      vecs[5] = '{1'b0, 3,  9,  {7'h7F, 7'h7F, 7'h7F, 7'b1000111}};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_head", 32'(head_pos), 32'(0));
      chk("rst_wrap", 32'(wrap), 32'(0));
      chk("rst_seg", 32'(seg), 32'(28'hFFFFFFF));
      chk("rst_dp", 32'(dp), 32'(4'hF));

      // Table: step from reset to a position, compare head and pattern
      for (int v = 0; v < 6; v++) begin
         run = 1'b0;
         dir = vecs[v].dir;
         do_reset();
         for (int s = 0; s < vecs[v].steps; s++) step_pulse();
         @(negedge clk);
         chk($sformatf("tbl%0d_head", v), 32'(head_pos), 32'(vecs[v].head));
         chk($sformatf("tbl%0d_seg", v), 32'(seg), 32'(vecs[v].seg));
      end

      // Free-running cw lap
      dir = 1'b1;
      run = 1'b1;
      do_reset();
      repeat (2) @(negedge clk);
      chk("run_first_seg", 32'(seg), 32'(vecs[0].seg));
      chk("run_first_head", 32'(head_pos), 32'(0));
      chk("run_first_dp", 32'(dp), 32'(dp_pat(0)));
      cyc   = 2;
      wraps = 0;
      wcyc  = -1;
      while (cyc < 52) begin
         @(negedge clk);
         cyc++;
         if (cyc == 16) chk("lap_head4", 32'(head_pos), 32'(4));
         if (cyc == 48) chk("lap_head0", 32'(head_pos), 32'(0));
         if (wrap) begin
            wraps++;
            wcyc = cyc;
         end
      end
      chk("lap_wrap_count", 32'(wraps), 32'(1));
      chk("lap_wrap_cycle", 32'(wcyc), 32'(48));

      // Counter-clockwise first advance wraps to L-1
      dir = 1'b0;
      run = 1'b1;
      do_reset();
      repeat (3) @(negedge clk);
      chk("ccw_head_pre", 32'(head_pos), 32'(0));
      @(negedge clk);
      chk("ccw_head", 32'(head_pos), 32'(11));
      chk("ccw_wrap", 32'(wrap), 32'(1));
      @(negedge clk);
      chk("ccw_wrap_clr", 32'(wrap), 32'(0));
      chk("ccw_seg", 32'(seg), 32'(vecs[2].seg));

      // Held step gives one advance; step ignored while running
      dir = 1'b1;
      run = 1'b0;
      do_reset();
      step = 1'b1;
      repeat (5) @(negedge clk);
      chk("step_hold", 32'(head_pos), 32'(1));
      step = 1'b0;
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      chk("step_second", 32'(head_pos), 32'(2));
      step = 1'b0;
      run  = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step = c[0];
         @(negedge clk);
      end
      step = 1'b0;
      chk("step_while_run", 32'(head_pos), 32'(4));

      // Reset in the middle of a prescale period
      run = 1'b1;
      dir = 1'b1;
      do_reset();
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (head_pos == 4'd7) found = 1'b1;
      end
      chk("wait_head7", 32'(head_pos), 32'(7));
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_head", 32'(head_pos), 32'(0));
      chk("midrst_wrap", 32'(wrap), 32'(0));
      chk("midrst_seg", 32'(seg), 32'(28'hFFFFFFF));
      rst_n = 1'b1;
      cnt = 0;
      found = 1'b0;
      while (cnt < 20 && !found) begin
         @(negedge clk);
         cnt++;
         if (head_pos != 4'd0) found = 1'b1;
      end
      chk("restart_latency", 32'(cnt), 32'(4));

      // Head decimal point
      run = 1'b0;
      dir = 1'b1;
      do_reset();
      for (int s = 0; s < 5; s++) step_pulse();
      @(negedge clk);
`ifdef SNAKE_DP_HEAD_EN
      chk("dp_p5", 32'(dp), 32'(4'b0111));
`else
      chk("dp_p5", 32'(dp), 32'(4'b1111));
`endif
      for (int s = 0; s < 3; s++) step_pulse();
      @(negedge clk);
`ifdef SNAKE_DP_HEAD_EN
      chk("dp_p8", 32'(dp), 32'(4'b1101));
`else
      chk("dp_p8", 32'(dp), 32'(4'b1111));
`endif

      // Randomised traffic against the model
      for (int c = 0; c < 3000; c++) begin
         chk("rnd_head", 32'(head_pos), 32'(m_head));
         chk("rnd_wrap", 32'(wrap), 32'(m_wrap));
         chk("rnd_seg", 32'(seg), 32'(m_seg));
         chk("rnd_dp", 32'(dp), 32'(m_dp));
         rst_n = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 15) == 0) run = ~run;
         if ($urandom_range(0, 7) == 0) dir = ~dir;
         step = 1'($urandom_range(0, 1));
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
